// File: rtl/cntr_cmd_seq_pkg.sv
// Shared definitions for the counter command sequencer.
//   - Command opcodes carried on cmd_op.
//   - FSM state encoding.
//   - Default widths.
//   - A small opcode-classification helper.
package cntr_cmd_seq_pkg;

  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned LEN_W_DEF  = 8;
  localparam int unsigned WRAP_W_DEF = 8;

  typedef enum logic [1:0] {
    OP_NOP      = 2'b00,
    OP_LOAD     = 2'b01,
    OP_RUN      = 2'b10,
    OP_LOAD_RUN = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // True for commands that open a counting window (and so restart the wrap tally).
  function automatic logic op_runs(input cmd_op_e op);
    return (op == OP_RUN) || (op == OP_LOAD_RUN);
  endfunction

endpackage

// File: rtl/cntr_cmd_seq.sv
// Command sequencer driving a 4-bit parallel-load counter.
//
// Accepts NOP / LOAD / RUN / LOAD_RUN over a valid/ready handshake. It then
// produces a one-cycle load pulse and/or a cnt_en window of cmd_len cycles.
// It also counts the carry events seen during the window (saturating).
// All counter-side outputs come straight from flops, so no combinational
// path exists from cmd_* to the counter pins.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   cmd_valid  command present
//   cmd_ready  sequencer idle and able to accept
//   cmd_op     00 NOP, 01 LOAD, 10 RUN, 11 LOAD_RUN
//   cmd_data   parallel load value
//   cmd_len    number of cnt_en cycles
//   abort      ends an active RUN after the current cycle
//   cnt_en     counter count enable
//   load       counter parallel load strobe
//   I          counter parallel data (holds last loaded value)
//   carry      counter carry-out
//   busy       command in progress (LOAD/RUN/DONE)
//   done       one-cycle completion pulse
//   wraps      carry events seen in the last run (saturating)
module cntr_cmd_seq
  import cntr_cmd_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF,
  parameter int unsigned WRAP_W = WRAP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              abort,
  output logic              cnt_en,
  output logic              load,
  output logic [DATA_W-1:0] I,
  input  logic              carry,
  output logic              busy,
  output logic              done,
  output logic [WRAP_W-1:0] wraps
);

  state_e              state_q;
  cmd_op_e             op_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    rem_q;
  logic [DATA_W-1:0]   i_q;
  logic [WRAP_W-1:0]   wraps_q;
  logic                cnt_en_q;
  logic                load_q;
  logic                busy_q;
  logic                done_q;

  // Accept only in IDLE; rst masks ready so nothing is taken during reset.
  assign cmd_ready = (state_q == ST_IDLE) && !rst;

  assign cnt_en = cnt_en_q;
  assign load   = load_q;
  assign I      = i_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign wraps  = wraps_q;

  // Sequencer FSM with registered counter controls, status and wrap tally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_NOP;
      len_q    <= {LEN_W{1'b0}};
      rem_q    <= {LEN_W{1'b0}};
      i_q      <= {DATA_W{1'b0}};
      wraps_q  <= {WRAP_W{1'b0}};
      cnt_en_q <= 1'b0;
      load_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op_e'(cmd_op);
            len_q  <= cmd_len;
            busy_q <= 1'b1;
            if (op_runs(cmd_op_e'(cmd_op))) begin
              wraps_q <= {WRAP_W{1'b0}};
            end
            case (cmd_op_e'(cmd_op))
              OP_LOAD, OP_LOAD_RUN: begin
                state_q <= ST_LOAD;
                load_q  <= 1'b1;
                i_q     <= cmd_data;
              end
              OP_RUN: begin
                // A zero length never enters RUN, so rem_q cannot underflow.
                if (cmd_len != {LEN_W{1'b0}}) begin
                  state_q  <= ST_RUN;
                  cnt_en_q <= 1'b1;
                  rem_q    <= cmd_len;
                end else begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                end
              end
              default: begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end
            endcase
          end
        end

        ST_LOAD: begin
          load_q <= 1'b0;
          if ((op_q == OP_LOAD_RUN) && (len_q != {LEN_W{1'b0}})) begin
            state_q  <= ST_RUN;
            cnt_en_q <= 1'b1;
            rem_q    <= len_q;
          end else begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end

        ST_RUN: begin
          // carry is only meaningful while cnt_en is high, i.e. in RUN.
          if (carry && !(&wraps_q)) begin
            wraps_q <= wraps_q + WRAP_W'(1);
          end
          // rem_q counts the RUN cycles still owed including this one.
          if (abort || (rem_q == LEN_W'(1))) begin
            state_q  <= ST_DONE;
            cnt_en_q <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            rem_q <= rem_q - LEN_W'(1);
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q  <= ST_IDLE;
          cnt_en_q <= 1'b0;
          load_q   <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cntr_cmd_seq.sv
// Bench for cntr_cmd_seq.
// Pairs the sequencer with a behavioural 4-bit parallel-load counter.
// The counter's active-low reset is tied to !rst.
module tb_cntr_cmd_seq;

  localparam int DATA_W = 4;
  localparam int LEN_W  = 8;
  localparam int WRAP_W = 3;   // small so saturation (7) is reachable

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic [LEN_W-1:0]  cmd_len;
  logic              abort;
  logic              cnt_en;
  logic              load;
  logic [DATA_W-1:0] I;
  logic              carry;
  logic              busy;
  logic              done;
  logic [WRAP_W-1:0] wraps;

  logic [3:0]        count_q;
  logic              cnt_rstn;

  always #5 clk = ~clk;

  cntr_cmd_seq #(.DATA_W(DATA_W), .LEN_W(LEN_W), .WRAP_W(WRAP_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_len(cmd_len), .abort(abort),
    .cnt_en(cnt_en), .load(load), .I(I), .carry(carry), .busy(busy),
    .done(done), .wraps(wraps)
  );

  // Behavioural 4-bit synchronous parallel-load counter.
  assign cnt_rstn = !rst;
  always @(posedge clk) begin
    if (!cnt_rstn)   count_q <= 4'h0;
    else if (load)   count_q <= I;
    else if (cnt_en) count_q <= count_q + 4'h1;
  end
  assign carry = cnt_en && (count_q == 4'hF);

  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    logic [7:0] len;
    int lat;      // cycle (after accept edge) in which done is high
    int en_n;     // number of cnt_en cycles
    int ld_n;     // number of load cycles
    int wr;       // wraps afterwards
    int cnt;      // counter value afterwards
    int ival;     // I afterwards
  } vec_t;

  vec_t vecs[10];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Issue one command from an IDLE negedge and follow it until done.
  // Returns one negedge into the IDLE cycle after DONE.
  task automatic send(input logic [1:0] op, input logic [3:0] d, input logic [7:0] l,
                      input string tag, output int lat, output int en_n, output int ld_n);
    cmd_op = op; cmd_data = d; cmd_len = l; cmd_valid = 1'b1;
    check({tag, "_ready"}, int'(cmd_ready), 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = -1; en_n = 0; ld_n = 0;
    for (int c = 1; c <= 400; c++) begin
      if (cnt_en) en_n++;
      if (load)   ld_n++;
      if (done) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) check({tag, "_done_timeout"}, 0, 1);
    @(negedge clk);
  endtask

  initial begin
    int lat, en_n, ld_n, accepts, first_rdy, ld_cyc;

    vecs[0] = '{2'b01, 4'hA, 8'd0,   2,   0,  1, 0, 10, 10};  // LOAD A
    vecs[1] = '{2'b11, 4'hF, 8'd3,   5,   3,  1, 1,  2, 15};  // LOAD_RUN F,3
    vecs[2] = '{2'b10, 4'h0, 8'd0,   1,   0,  0, 0,  2, 15};  // RUN 0
    vecs[3] = '{2'b01, 4'h0, 8'd0,   2,   0,  1, 0,  0,  0};  // LOAD 0
    vecs[4] = '{2'b10, 4'h0, 8'd40,  41,  40, 0, 2,  8,  0};  // RUN 40
    vecs[5] = '{2'b00, 4'h7, 8'd9,   1,   0,  0, 2,  8,  0};  // NOP keeps wraps
    vecs[6] = '{2'b01, 4'h5, 8'd0,   2,   0,  1, 2,  5,  5};  // LOAD keeps wraps
    vecs[7] = '{2'b11, 4'h3, 8'd0,   2,   0,  1, 0,  3,  3};  // LOAD_RUN len 0
    vecs[8] = '{2'b11, 4'hE, 8'd20,  22,  20, 1, 2,  2, 14};  // LOAD_RUN E,20
    vecs[9] = '{2'b10, 4'h0, 8'd255, 256, 255, 0, 7, 1, 14};  // RUN 255, saturates

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 4'h0;
    cmd_len = 8'd0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cnt_en", int'(cnt_en), 0);
    check("rst_load",   int'(load),   0);
    check("rst_I",      int'(I),      0);
    check("rst_busy",   int'(busy),   0);
    check("rst_done",   int'(done),   0);
    check("rst_wraps",  int'(wraps),  0);
    check("rst_ready",  int'(cmd_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", int'(cmd_ready), 1);

    for (int v = 0; v < 10; v++) begin
      string t;
      t = $sformatf("v%0d", v);
      send(vecs[v].op, vecs[v].data, vecs[v].len, t, lat, en_n, ld_n);
      check({t, "_done_lat"}, lat,  vecs[v].lat);
      check({t, "_en_cycles"}, en_n, vecs[v].en_n);
      check({t, "_ld_cycles"}, ld_n, vecs[v].ld_n);
      check({t, "_wraps"}, int'(wraps),   vecs[v].wr);
      check({t, "_count"}, int'(count_q), vecs[v].cnt);
      check({t, "_I"},     int'(I),       vecs[v].ival);
      check({t, "_idle_busy"}, int'(busy), 0);
    end

    // Abort on the 5th RUN cycle of a long run.
    cmd_op = 2'b10; cmd_len = 8'd200; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = -1; en_n = 0;
    for (int c = 1; c <= 300; c++) begin
      if (done) begin
        lat = c;
        abort = 1'b0;
        break;
      end
      if (cnt_en) begin
        en_n++;
        abort = (en_n == 5);
      end else begin
        abort = 1'b0;
      end
      @(negedge clk);
    end
    check("abort_en_cycles", en_n, 5);
    check("abort_done_lat", lat, 6);
    check("abort_ready_in_done", int'(cmd_ready), 0);
    @(negedge clk);
    check("abort_ready_after", int'(cmd_ready), 1);

    // Reset in the middle of a RUN.
    cmd_op = 2'b10; cmd_len = 8'd50; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_running", int'(cnt_en), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cnt_en", int'(cnt_en), 0);
    check("midrst_busy",   int'(busy),   0);
    check("midrst_wraps",  int'(wraps),  0);
    check("midrst_ready",  int'(cmd_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready_after", int'(cmd_ready), 1);

    // cmd_valid held across a busy RUN is taken once, at the first IDLE cycle.
    cmd_op = 2'b10; cmd_len = 8'd4; cmd_data = 4'h0; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_op = 2'b01; cmd_data = 4'h9;
    accepts = 0; first_rdy = -1; lat = -1; ld_cyc = -1;
    for (int c = 1; c <= 15; c++) begin
      if (cmd_ready && cmd_valid) begin
        accepts++;
        if (first_rdy < 0) first_rdy = c;
      end
      if (done && lat < 0) lat = c;
      if (load && ld_cyc < 0) ld_cyc = c;
      if (first_rdy > 0 && c == first_rdy + 1) cmd_valid = 1'b0;
      @(negedge clk);
    end
    check("held_run_done", lat, 5);
    check("held_first_accept", first_rdy, 6);
    check("held_accepts", accepts, 1);
    check("held_load_cycle", ld_cyc, 7);
    check("held_I", int'(I), 9);
    check("held_count", int'(count_q), 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cntr_cmd_seq.md
Name: cntr_cmd_seq

Overview:
Command sequencer that sits directly upstream of the 4-bit synchronous parallel-load counter and drives its control pins (cnt_en, load, I).
- Accepts LOAD / RUN / LOAD_RUN commands over a valid/ready handshake.
- Times the counter's enable window.
- Monitors the counter's carry output to report how many wraps occurred during a run.
- Lets a controller or testbench script the counter without cycle-exact pin wiggling.

Parameters:
DATA_W, 4, width of counter load value (matches counter width)
LEN_W, 8, width of run-length field (max 2^LEN_W-1 count cycles)
WRAP_W, 8, width of wrap-event counter (saturating)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  2  00 NOP, 01 LOAD, 10 RUN, 11 LOAD_RUN
cmd_data  in  DATA_W  load value
cmd_len  in  LEN_W  number of count-enable cycles
abort  in  1  terminate an active RUN early
cnt_en  out  1  to counter count enable
load  out  1  to counter parallel load
I  out  DATA_W  to counter parallel data
carry  in  1  from counter, high when count==all-ones and cnt_en high
busy  out  1  command in progress
done  out  1  one-cycle completion pulse
wraps  out  WRAP_W  carry events seen in the last run

Behaviour:
- Single clock domain: clk. Reset rst is synchronous, active-high.
- Reset values: state=IDLE, cnt_en=0, load=0, I=0, busy=0, done=0, wraps=0. cmd_ready=0 while rst is high, 1 in the cycle after reset.
- Reset mid-operation aborts immediately. The counter is left holding whatever value it had.
- FSM states: IDLE, LOAD, RUN, DONE. cnt_en and load are decoded from registered state; there is no combinational path from cmd_* to counter pins.
- Handshake:
  - cmd_ready = (state==IDLE) && !rst.
  - Accept = cmd_valid && cmd_ready, at edge T.
  - cmd_data and cmd_len are captured at T.
  - cmd_valid held while busy is not accepted and not lost.
- Transitions from IDLE on accept:
  - NOP -> DONE.
  - LOAD -> LOAD.
  - LOAD_RUN -> LOAD.
  - RUN -> RUN if len!=0, else DONE.
- LOAD state (exactly 1 cycle): load=1, I=captured data, cnt_en=0. Next state: RUN if op==LOAD_RUN and len!=0, else DONE.
- RUN state:
  - cnt_en=1, load=0.
  - A remaining-cycles register starts at len and decrements each RUN cycle.
  - Exit to DONE after exactly len RUN cycles (cnt_en high for exactly len cycles).
  - abort high in a RUN cycle: that cycle still has cnt_en=1; next state DONE.
  - abort is ignored in all other states.
- I holds the last loaded value outside LOAD; it only changes on a LOAD.
- DONE state (1 cycle): done=1, cnt_en=0, load=0, then -> IDLE.
- busy=1 in LOAD, RUN and DONE.
- wraps:
  - Cleared to 0 on accept of RUN or LOAD_RUN; unchanged by LOAD and NOP.
  - Incremented in every RUN cycle with carry=1.
  - Saturates at 2^WRAP_W-1.
  - Held stable from DONE until the next clearing accept.
- Width rules: len is unsigned. The remaining-cycles counter never underflows; len=0 never enters RUN.
- Back-to-back commands: minimum spacing is one IDLE cycle after DONE.
- Latencies from accept edge T:
  - LOAD: load high in cycle T+1, done in T+2.
  - RUN len n: cnt_en high in T+1..T+n, done in T+n+1.
  - LOAD_RUN adds one cycle to the RUN figure.

Decomposition:
- Shared package: op encodings (OP_NOP, OP_LOAD, OP_RUN, OP_LOAD_RUN), state encodings, default widths.
- No sub-module is required.
- Bench-level top instantiates cntr_cmd_seq feeding the 4-bit counter, with counter rstn tied to !rst.

Test Plan:
- Reset, then LOAD data=4'hA -> load=1 and I=A in cycle T+1 only. done at T+2. Counter count=A. wraps=0.
- LOAD_RUN data=4'hF len=3 -> load at T+1. cnt_en T+2..T+4. carry seen at first run cycle so wraps=1. Final count=2. done at T+5.
- RUN len=0 -> no cnt_en. done at T+1. wraps=0.
- Counter at 0, RUN len=40 -> cnt_en for 40 cycles. wraps=2. Final count=8.
- RUN len=200 with abort at 5th RUN cycle -> cnt_en for exactly 5 cycles. done next cycle. cmd_ready returns after DONE.
- rst asserted during RUN -> next cycle cnt_en=0, busy=0, wraps=0. A cmd_valid held across busy is accepted only once, at the first IDLE cycle after done.
